dsp_preadd_macc_pipe: RTL and testbench

//  Parametrised pre-add/sub -> multiply -> post-add/sub/accumulate pipeline.
//  Per-sample opcode and valid tag; optional saturation with a sticky overflow flag.
//  The D operand is delay-matched to the product.

---
 rtl/dsp_preadd_macc_pipe_pkg.sv | 37 +++
 rtl/dsp_preadd_macc_pipe_if.sv | 23 ++
 rtl/dsp_preadd_macc_pipe_sat_adder.sv | 27 ++
 rtl/dsp_preadd_macc_pipe.sv | 98 +++++++++
 tb/tb_dsp_preadd_macc_pipe.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dsp_preadd_macc_pipe_pkg.sv
// rtl/dsp_preadd_macc_pipe_pkg.sv - shared opcodes, widths and saturation helper
package dsp_preadd_macc_pipe_pkg;

  localparam int OP_W  = 2;
  // Widest intermediate the saturation helper handles; ACC_W+1 must not exceed it.
  localparam int MAX_W = 64;

  localparam logic [OP_W-1:0] OP_ADD_D = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB_D = 2'b01;
  localparam logic [OP_W-1:0] OP_ACC   = 2'b10;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'b11;

  // Returns {ovf, result}: ovf when value is outside the signed range of 'width'.
  // With sat_en the result clamps to that range; otherwise the low bits wrap.
  function automatic logic [MAX_W:0] sat_trunc(input logic signed [MAX_W-1:0] value,
                                               input int unsigned width,
                                               input logic sat_en);
    logic        [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic        [MAX_W:0]   r;
    one    = '0;
    one[0] = 1'b1;
    hi     = $signed((one << (width - 1)) - one);
    lo     = ~hi;
    r      = {1'b0, value};
    if (value > hi) begin
      r[MAX_W] = 1'b1;
      if (sat_en) r[MAX_W-1:0] = hi;
    end else if (value < lo) begin
      r[MAX_W] = 1'b1;
      if (sat_en) r[MAX_W-1:0] = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_preadd_macc_pipe_if.sv
// rtl/dsp_preadd_macc_pipe_if.sv - sample/result bus of the pre-add MACC pipeline
interface dsp_preadd_macc_pipe_if
  import dsp_preadd_macc_pipe_pkg::*;
#(
  parameter int SIZEIN = 16,
  parameter int ACC_W  = 2 * SIZEIN + 8
);
  logic                     in_valid;
  logic                     pre_sub;
  logic        [OP_W-1:0]   post_op;
  logic signed [SIZEIN-1:0] a;
  logic signed [SIZEIN-1:0] b;
  logic signed [SIZEIN-1:0] c;
  logic signed [SIZEIN-1:0] d;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  p;
  logic                     ovf;

  modport master (output in_valid, pre_sub, post_op, a, b, c, d,
                  input  out_valid, p, ovf);
  modport slave  (input  in_valid, pre_sub, post_op, a, b, c, d,
                  output out_valid, p, ovf);
endinterface

// File: rtl/dsp_preadd_macc_pipe_sat_adder.sv
// rtl/dsp_preadd_macc_pipe_sat_adder.sv - W-bit signed add/sub with overflow detect and optional clamp
module dsp_preadd_macc_pipe_sat_adder
  import dsp_preadd_macc_pipe_pkg::*;
#(
  parameter int W      = 40,
  parameter int SAT_EN = 0
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic                sub_i,
  output logic signed [W-1:0] sum_o,
  output logic                ovf_o
);
  logic signed [W:0]     x_ext;
  logic signed [W:0]     y_ext;
  logic signed [W:0]     full;
  logic        [MAX_W:0] st;

  // Exact sum one bit wider than the operands, then reduced back to W bits.
  always_comb begin
    x_ext = {x_i[W-1], x_i};
    y_ext = {y_i[W-1], y_i};
    full  = sub_i ? (x_ext - y_ext) : (x_ext + y_ext);
    st    = sat_trunc({{(MAX_W-W-1){full[W]}}, full}, W, SAT_EN != 0);
    {ovf_o, sum_o} = {st[MAX_W], W'(st[MAX_W-1:0])};
  end
endmodule

// File: rtl/dsp_preadd_macc_pipe.sv
// rtl/dsp_preadd_macc_pipe.sv - 3-stage pre-add, multiply, post-add/accumulate pipeline
module dsp_preadd_macc_pipe
  import dsp_preadd_macc_pipe_pkg::*;
#(
  parameter int SIZEIN = 16,
  parameter int ACC_W  = 2 * SIZEIN + 8,
  parameter int SAT_EN = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  dsp_preadd_macc_pipe_if.slave  bus
);
  localparam int PRE_W  = SIZEIN + 1;
  localparam int PROD_W = 2 * SIZEIN + 1;

  logic signed [SIZEIN-1:0] a_q, b_q, c_q, d1_q, d2_q;
  logic                     pre_sub_q, v1_q, v2_q;
  logic        [OP_W-1:0]   op1_q, op2_q;
  logic signed [PRE_W-1:0]  pre_d;
  logic signed [PROD_W-1:0] m_d, m_q;
  logic signed [ACC_W-1:0]  m_ext, d_ext, x_d, y_d, sum_d, p_d, p_q;
  logic                     sub_d, add_ovf, ovf_d, ovf_q, out_valid_d, out_valid_q;

  // S1: capture the incoming sample and its tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; c_q <= '0; d1_q <= '0;
      pre_sub_q <= 1'b0; op1_q <= '0; v1_q <= 1'b0;
    end else if (ce) begin
      a_q <= bus.a; b_q <= bus.b; c_q <= bus.c; d1_q <= bus.d;
      pre_sub_q <= bus.pre_sub; op1_q <= bus.post_op; v1_q <= bus.in_valid;
    end
  end

  // S2 datapath: sign-extended pre-add/sub feeding the full-precision multiply.
  always_comb begin
    pre_d = pre_sub_q ? ({a_q[SIZEIN-1], a_q} - {b_q[SIZEIN-1], b_q})
                      : ({a_q[SIZEIN-1], a_q} + {b_q[SIZEIN-1], b_q});
    m_d   = pre_d * c_q;
  end

  // S2: register the product; D and tags get their second delay to line up with M.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0; d2_q <= '0; op2_q <= '0; v2_q <= 1'b0;
    end else if (ce) begin
      m_q <= m_d; d2_q <= d1_q; op2_q <= op1_q; v2_q <= v1_q;
    end
  end

  // S3 operand select: accumulate feeds back the registered P, load adds zero.
  always_comb begin
    m_ext = {{(ACC_W-PROD_W){m_q[PROD_W-1]}}, m_q};
    d_ext = {{(ACC_W-SIZEIN){d2_q[SIZEIN-1]}}, d2_q};
    x_d   = m_ext;
    y_d   = d_ext;
    sub_d = 1'b0;
    case (op2_q)
      OP_SUB_D: sub_d = 1'b1;
      OP_ACC:   begin x_d = p_q; y_d = m_ext; end
      OP_LOAD:  y_d = '0;
      default:  ;
    endcase
  end

  dsp_preadd_macc_pipe_sat_adder #(.W(ACC_W), .SAT_EN(SAT_EN)) u_sat_adder (
    .x_i  (x_d),
    .y_i  (y_d),
    .sub_i(sub_d),
    .sum_o(sum_d),
    .ovf_o(add_ovf)
  );

  // S3 next state: bubbles keep P and the flag; a load restarts the sticky flag.
  always_comb begin
    p_d         = p_q;
    ovf_d       = ovf_q;
    out_valid_d = v2_q;
    if (v2_q) begin
      p_d   = sum_d;
      ovf_d = (op2_q == OP_LOAD) ? add_ovf : (ovf_q | add_ovf);
    end
  end

  // S3: result, sticky overflow and output valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0; ovf_q <= 1'b0; out_valid_q <= 1'b0;
    end else if (ce) begin
      p_q <= p_d; ovf_q <= ovf_d; out_valid_q <= out_valid_d;
    end
  end

  assign bus.p         = p_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_dsp_preadd_macc_pipe.sv
// tb/tb_dsp_preadd_macc_pipe.sv - directed self-checking bench for the pre-add MACC pipeline
module tb_dsp_preadd_macc_pipe;
  import dsp_preadd_macc_pipe_pkg::*;

  logic clk, rst, ce;
  int   total, bad;

  dsp_preadd_macc_pipe_if #(.SIZEIN(16), .ACC_W(40)) bus0 ();
  dsp_preadd_macc_pipe_if #(.SIZEIN(16), .ACC_W(34)) bus_s ();
  dsp_preadd_macc_pipe_if #(.SIZEIN(16), .ACC_W(34)) bus_w ();

  dsp_preadd_macc_pipe #(.SIZEIN(16), .ACC_W(40), .SAT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus0.slave));
  dsp_preadd_macc_pipe #(.SIZEIN(16), .ACC_W(34), .SAT_EN(1)) dut_s (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus_s.slave));
  dsp_preadd_macc_pipe #(.SIZEIN(16), .ACC_W(34), .SAT_EN(0)) dut_w (
    .clk(clk), .rst(rst), .ce(ce), .bus(bus_w.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic signed [15:0] NEG = -16'sd32768;

  task automatic drive(input logic v, input logic ps, input logic [1:0] op,
                       input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic signed [15:0] c, input logic signed [15:0] d);
    bus0.in_valid  = v;  bus0.pre_sub  = ps; bus0.post_op  = op;
    bus0.a = a;  bus0.b = b;  bus0.c = c;  bus0.d = d;
    bus_s.in_valid = v;  bus_s.pre_sub = ps; bus_s.post_op = op;
    bus_s.a = a; bus_s.b = b; bus_s.c = c; bus_s.d = d;
    bus_w.in_valid = v;  bus_w.pre_sub = ps; bus_w.post_op = op;
    bus_w.a = a; bus_w.b = b; bus_w.c = c; bus_w.d = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic ov, input logic signed [63:0] p);
    chk({tag, "_ov"}, 64'(bus0.out_valid), 64'(ov));
    chk({tag, "_p"},  64'(bus0.p), p);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ce    = 1'b1;
    idle();
    tick(); tick();
    chk("rst_ov",   64'(bus0.out_valid), 64'sd0);
    chk("rst_p",    64'(bus0.p),         64'sd0);
    chk("rst_ovf",  64'(bus0.ovf),       64'sd0);
    chk("rst_ovfs", 64'(bus_s.ovf),      64'sd0);
    rst = 1'b0;
    tick();

    // 1: single sample, (3+2)*4+5 = 25, then held.
    drive(1'b1, 1'b0, OP_ADD_D, 16'sd3, 16'sd2, 16'sd4, 16'sd5); tick();
    idle(); tick();
    chk0("t1_early", 1'b0, 64'sd0);
    tick();
    chk0("t1", 1'b1, 64'sd25);
    tick();
    chk0("t1_hold", 1'b0, 64'sd25);

    // 2: back-to-back, 25 then (3-5)*(-7)-10 = 4.
    drive(1'b1, 1'b0, OP_ADD_D, 16'sd3, 16'sd2, 16'sd4, 16'sd5); tick();
    drive(1'b1, 1'b1, OP_SUB_D, 16'sd3, 16'sd5, -16'sd7, 16'sd10); tick();
    idle(); tick();
    chk0("t2_a", 1'b1, 64'sd25);
    tick();
    chk0("t2_b", 1'b1, 64'sd4);
    tick();
    chk0("t2_hold", 1'b0, 64'sd4);

    // 3: load 2, accumulate with a bubble in the middle.
    drive(1'b1, 1'b0, OP_LOAD, 16'sd1, 16'sd0, 16'sd2, 16'sd0); tick();
    drive(1'b1, 1'b0, OP_ACC,  16'sd1, 16'sd0, 16'sd2, 16'sd0); tick();
    idle(); tick();
    chk0("t3_ld", 1'b1, 64'sd2);
    drive(1'b1, 1'b0, OP_ACC,  16'sd1, 16'sd0, 16'sd2, 16'sd0); tick();
    chk0("t3_acc1", 1'b1, 64'sd4);
    drive(1'b1, 1'b0, OP_ACC,  16'sd1, 16'sd0, 16'sd2, 16'sd0); tick();
    chk0("t3_bub", 1'b0, 64'sd4);
    idle(); tick();
    chk0("t3_acc2", 1'b1, 64'sd6);
    tick();
    chk0("t3_acc3", 1'b1, 64'sd8);
    tick();

    // 4/5: M = 2^31, load then accumulate; ACC_W=34 overflows on the 3rd accumulate.
    drive(1'b1, 1'b0, OP_LOAD, NEG, NEG, NEG, 16'sd0); tick();
    drive(1'b1, 1'b0, OP_ACC,  NEG, NEG, NEG, 16'sd0); tick();
    drive(1'b1, 1'b0, OP_ACC,  NEG, NEG, NEG, 16'sd0); tick();
    chk("t4_ld_s", 64'(bus_s.p), 64'sd2147483648);
    chk("t4_ld_w", 64'(bus_w.p), 64'sd2147483648);
    drive(1'b1, 1'b0, OP_ACC,  NEG, NEG, NEG, 16'sd0); tick();
    chk("t4_a1_s", 64'(bus_s.p), 64'sd4294967296);
    drive(1'b1, 1'b0, OP_ACC,  NEG, NEG, NEG, 16'sd0); tick();
    chk("t4_a2_s",   64'(bus_s.p),   64'sd6442450944);
    chk("t4_a2_ovf", 64'(bus_s.ovf), 64'sd0);
    drive(1'b1, 1'b0, OP_LOAD, 16'sd1, 16'sd0, 16'sd2, 16'sd0); tick();
    chk("t4_a3_s",     64'(bus_s.p),   64'sd8589934591);
    chk("t4_a3_s_ovf", 64'(bus_s.ovf), 64'sd1);
    chk("t5_a3_w",     64'(bus_w.p),   -64'sd8589934592);
    chk("t5_a3_w_ovf", 64'(bus_w.ovf), 64'sd1);
    idle(); tick();
    chk("t4_a4_s",     64'(bus_s.p),   64'sd8589934591);
    chk("t4_a4_s_ovf", 64'(bus_s.ovf), 64'sd1);
    chk("t5_a4_w",     64'(bus_w.p),   -64'sd6442450944);
    chk("t5_sticky_w", 64'(bus_w.ovf), 64'sd1);
    chk("wide_a4_p",   64'(bus0.p),    64'sd10737418240);
    chk("wide_a4_ovf", 64'(bus0.ovf),  64'sd0);
    tick();
    chk("t4_clr_p",   64'(bus_s.p),   64'sd2);
    chk("t4_clr_ovf", 64'(bus_s.ovf), 64'sd0);
    chk("t5_clr_ovf", 64'(bus_w.ovf), 64'sd0);
    tick(); tick();

    // 6a: two cycles of ce=0 delay the stream by two cycles and freeze outputs.
    drive(1'b1, 1'b0, OP_ADD_D, 16'sd3, 16'sd2, 16'sd4, 16'sd5); tick();
    drive(1'b1, 1'b1, OP_SUB_D, 16'sd3, 16'sd5, -16'sd7, 16'sd10); tick();
    idle(); ce = 1'b0; tick();
    chk0("t6_frz1", 1'b0, 64'sd2);
    tick();
    chk0("t6_frz2", 1'b0, 64'sd2);
    ce = 1'b1; tick();
    chk0("t6_a", 1'b1, 64'sd25);
    tick();
    chk0("t6_b", 1'b1, 64'sd4);
    tick();
    chk0("t6_hold", 1'b0, 64'sd4);

    // 6b: build an overflow, then reset with samples in flight.
    drive(1'b1, 1'b0, OP_LOAD, NEG, NEG, NEG, 16'sd0); tick();
    drive(1'b1, 1'b0, OP_ACC,  NEG, NEG, NEG, 16'sd0); tick();
    drive(1'b1, 1'b0, OP_ACC,  NEG, NEG, NEG, 16'sd0); tick();
    drive(1'b1, 1'b0, OP_ACC,  NEG, NEG, NEG, 16'sd0); tick();
    idle(); tick(); tick();
    chk("t6_pre_ovf", 64'(bus_s.ovf), 64'sd1);
    drive(1'b1, 1'b0, OP_ADD_D, 16'sd3, 16'sd2, 16'sd4, 16'sd5); tick();
    drive(1'b1, 1'b1, OP_SUB_D, 16'sd3, 16'sd5, -16'sd7, 16'sd10); rst = 1'b1; tick();
    chk0("t6_rst", 1'b0, 64'sd0);
    chk("t6_rst_ovf", 64'(bus_s.ovf), 64'sd0);
    chk("t6_rst_ps",  64'(bus_s.p),   64'sd0);
    rst = 1'b0; idle(); tick();
    chk0("t6_lost1", 1'b0, 64'sd0);
    tick();
    chk0("t6_lost2", 1'b0, 64'sd0);
    tick();
    chk0("t6_lost3", 1'b0, 64'sd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
